// File: rtl/led_mux_arbiter.sv
// rtl/led_mux_arbiter.sv - round-robin arbiter and hold sequencer for the shared 4-bit 2:1 LED mux
module led_mux_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CW          = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       req_x,
    input  logic [3:0] x,
    input  logic       req_y,
    input  logic [3:0] y,
    output logic       gnt_x,
    output logic       gnt_y,
    output logic       s,
    output logic [3:0] M,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD_X = 2'b01,
        HOLD_Y = 2'b10
    } state_t;

    localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          last_y;
    logic          last_y_nxt;
    logic          s_nxt;
    logic [3:0]    m_nxt;
    logic          expire;
    logic          win_x;
    logic          win_y;

    // last_y records the most recent winner; on a tie the other source wins
    assign win_x = req_x && (!req_y || last_y);
    assign win_y = req_y && (!req_x || !last_y);

    assign gnt_x  = (state == HOLD_X);
    assign gnt_y  = (state == HOLD_Y);
    assign busy   = gnt_x || gnt_y;
    assign expire = busy && (count == '0);
    assign done   = expire;

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        last_y_nxt = last_y;
        s_nxt      = s;
        m_nxt      = M;

        if (busy) begin
            m_nxt     = s ? y : x;
            count_nxt = count - 1'b1;
        end

        // arbitration happens in IDLE and on the last cycle of a grant, so grants chain with no bubble
        if ((state == IDLE) || expire) begin
            if (win_x) begin
                state_nxt  = HOLD_X;
                count_nxt  = LOAD;
                s_nxt      = 1'b0;
                last_y_nxt = 1'b0;
            end else if (win_y) begin
                state_nxt  = HOLD_Y;
                count_nxt  = LOAD;
                s_nxt      = 1'b1;
                last_y_nxt = 1'b1;
            end else begin
                state_nxt  = IDLE;
                count_nxt  = '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            count  <= '0;
            last_y <= 1'b1;
            s      <= 1'b0;
            M      <= 4'h0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            last_y <= last_y_nxt;
            s      <= s_nxt;
            M      <= m_nxt;
        end
    end

endmodule

// File: tb/tb_led_mux_arbiter.sv
// tb/tb_led_mux_arbiter.sv - table-driven scoreboard bench for led_mux_arbiter (HOLD_CYCLES 4 and 1)
module tb_led_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_x = 1'b0;
    logic       req_y = 1'b0;
    logic [3:0] x = 4'h0;
    logic [3:0] y = 4'h0;

    logic       gnt_x0, gnt_y0, s0, busy0, done0;
    logic [3:0] m0;
    logic       gnt_x1, gnt_y1, s1, busy1, done1;
    logic [3:0] m1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #10 clk = ~clk;

    led_mux_arbiter #(.HOLD_CYCLES(4), .CW(16)) dut4 (
        .CLOCK_50(clk), .RESET(rst),
        .req_x(req_x), .x(x), .req_y(req_y), .y(y),
        .gnt_x(gnt_x0), .gnt_y(gnt_y0), .s(s0), .M(m0), .busy(busy0), .done(done0)
    );

    led_mux_arbiter #(.HOLD_CYCLES(1), .CW(16)) dut1 (
        .CLOCK_50(clk), .RESET(rst),
        .req_x(req_x), .x(x), .req_y(req_y), .y(y),
        .gnt_x(gnt_x1), .gnt_y(gnt_y1), .s(s1), .M(m1), .busy(busy1), .done(done1)
    );

    // packed outputs: {gnt_x, gnt_y, s, busy, done, M}
    logic [8:0] out4, out1;
    assign out4 = {gnt_x0, gnt_y0, s0, busy0, done0, m0};
    assign out1 = {gnt_x1, gnt_y1, s1, busy1, done1, m1};

    typedef struct {
        bit         rst_before;
        bit         use_dut1;
        bit         rx;
        logic [3:0] xv;
        bit         ry;
        logic [3:0] yv;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] sb[$];

    function automatic logic [8:0] ev(input bit gx, input bit gy, input bit sv, input bit dn, input logic [3:0] mv);
        return {gx, gy, sv, gx | gy, dn, mv};
    endfunction

    task automatic add(input bit rb, input bit d1, input bit rx, input logic [3:0] xv,
                       input bit ry, input logic [3:0] yv, input logic [8:0] e);
        vec_t v;
        v.rst_before = rb; v.use_dut1 = d1; v.rx = rx; v.xv = xv; v.ry = ry; v.yv = yv; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [8:0] got, input logic [8:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %b, expected %b ({gx,gy,s,busy,done,M})", name, idx, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_x = 1'b0; req_y = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // single requester X
        add(1, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,0,4'h0));
        add(0, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,0,4'hA));
        add(0, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,0,4'hA));
        add(0, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,1,4'hA));
        add(0, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,0,4'hA));
        add(0, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,0,4'hA));
        add(0, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,0,4'hA));
        add(0, 0, 1, 4'hA, 0, 4'h0, ev(1,0,0,1,4'hA));
        add(0, 0, 0, 4'hA, 0, 4'h0, ev(0,0,0,0,4'hA));
        // tie after reset: X first, then alternate with no bubble
        add(1, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,0,4'h0));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,0,4'h3));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,0,4'h3));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,1,4'h3));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(0,1,1,0,4'h3));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(0,1,1,0,4'hC));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(0,1,1,0,4'hC));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(0,1,1,1,4'hC));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,0,4'hC));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,0,4'h3));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,0,4'h3));
        add(0, 0, 1, 4'h3, 1, 4'hC, ev(1,0,0,1,4'h3));
        add(0, 0, 0, 4'h3, 0, 4'hC, ev(0,0,0,0,4'h3));
        // req_y pulsed for one cycle: full grant, then IDLE holding M and s
        add(0, 0, 0, 4'h3, 1, 4'h5, ev(0,1,1,0,4'h3));
        add(0, 0, 0, 4'h3, 0, 4'h5, ev(0,1,1,0,4'h5));
        add(0, 0, 0, 4'h3, 0, 4'h5, ev(0,1,1,0,4'h5));
        add(0, 0, 0, 4'h3, 0, 4'h5, ev(0,1,1,1,4'h5));
        add(0, 0, 0, 4'h3, 0, 4'h5, ev(0,0,1,0,4'h5));
        add(0, 0, 0, 4'h3, 0, 4'h5, ev(0,0,1,0,4'h5));
        // req_y arrives on the done cycle of an X grant
        add(0, 0, 1, 4'hA, 0, 4'h5, ev(1,0,0,0,4'h5));
        add(0, 0, 0, 4'hA, 0, 4'h5, ev(1,0,0,0,4'hA));
        add(0, 0, 0, 4'hA, 0, 4'h5, ev(1,0,0,0,4'hA));
        add(0, 0, 0, 4'hA, 0, 4'h5, ev(1,0,0,1,4'hA));
        add(0, 0, 0, 4'hA, 1, 4'h6, ev(0,1,1,0,4'hA));
        add(0, 0, 0, 4'hA, 0, 4'h6, ev(0,1,1,0,4'h6));
        add(0, 0, 0, 4'hA, 0, 4'h6, ev(0,1,1,0,4'h6));
        add(0, 0, 0, 4'hA, 0, 4'h6, ev(0,1,1,1,4'h6));
        // live tracking of y during a Y grant
        add(0, 0, 0, 4'hA, 1, 4'h1, ev(0,1,1,0,4'h1));
        add(0, 0, 0, 4'hA, 0, 4'h1, ev(0,1,1,0,4'h1));
        add(0, 0, 0, 4'hA, 0, 4'h7, ev(0,1,1,0,4'h7));
        add(0, 0, 0, 4'hA, 0, 4'h7, ev(0,1,1,1,4'h7));
        add(0, 0, 0, 4'hA, 0, 4'h7, ev(0,0,1,0,4'h7));
        // HOLD_CYCLES = 1 instance, both requesting
        add(1, 1, 1, 4'h3, 1, 4'hC, ev(1,0,0,1,4'h0));
        add(0, 1, 1, 4'h3, 1, 4'hC, ev(0,1,1,1,4'h3));
        add(0, 1, 1, 4'h3, 1, 4'hC, ev(1,0,0,1,4'hC));
        add(0, 1, 1, 4'h3, 1, 4'hC, ev(0,1,1,1,4'h3));
        add(0, 1, 1, 4'h3, 1, 4'hC, ev(1,0,0,1,4'hC));
        add(0, 1, 0, 4'h3, 0, 4'hC, ev(0,0,0,0,4'h3));

        do_reset();
        #1;
        check("reset_state_h4", 0, out4, 9'h000);
        check("reset_state_h1", 0, out1, 9'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            @(negedge clk);
            req_x = vecs[i].rx; x = vecs[i].xv;
            req_y = vecs[i].ry; y = vecs[i].yv;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            begin
                logic [8:0] got;
                logic [8:0] exp;
                got = vecs[i].use_dut1 ? out1 : out4;
                exp = sb.pop_front();
                check("row", i, got, exp);
                check("one_hot_grant", i, {7'b0, (gnt_x0 & gnt_y0) | (gnt_x1 & gnt_y1)}, 9'h000);
            end
        end

        // asynchronous reset in the middle of an X grant
        do_reset();
        @(negedge clk);
        req_x = 1'b1; x = 4'hA; req_y = 1'b0;
        @(posedge clk); #1;
        check("async_pre_grant", 0, out4, ev(1,0,0,0,4'h0));
        @(posedge clk); #1;
        check("async_pre_grant", 1, out4, ev(1,0,0,0,4'hA));
        #4;
        rst = 1'b1;
        #1;
        check("async_reset_h4", 0, out4, 9'h000);
        check("async_reset_h1", 0, out1, 9'h000);
        @(negedge clk);
        rst = 1'b0;
        req_x = 1'b1; x = 4'h3; req_y = 1'b1; y = 4'hC;
        @(posedge clk); #1;
        check("after_reset_x_first", 0, out4, ev(1,0,0,0,4'h0));
        @(posedge clk); #1;
        check("after_reset_x_first", 1, out4, ev(1,0,0,0,4'h3));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
